prog_loader: RTL and testbench

- Writer side of the CPU program-memory interface: accepts 16-bit instruction words from a host over a valid/ready handshake and builds the flat program image the CPU fetches from.
- Checks opcodes and guarantees the image ends in a halt word (opcode 4'b1111).
- Pulses cpu_start when the image is sealed.
- Sits between the host/testbench and the CPU's ProgramMEMORY input.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-image writer for the CPU program memory: collects host instruction words,
// guarantees a trailing halt word and pulses cpu_start. Optional readback: PROG_LOADER_READBACK_EN.
module prog_loader #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_word,
  output logic [DEPTH*16-1:0]   prog_image,
  output logic [CW-1:0]         word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_start,
  output logic                  err_illegal,
  output logic                  err_overflow
`ifdef PROG_LOADER_READBACK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [15:0]              rd_data
`endif
);

  localparam logic [15:0] HALT_WORD = 16'hF000;
  localparam logic [3:0]  OP_ADD    = 4'b0000;
  localparam logic [3:0]  OP_SUB    = 4'b0001;
  localparam logic [3:0]  OP_HALT   = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEAL, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_ill_q, err_ill_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   in_ready_q, busy_q, done_q, cpu_start_q;
  logic                   clear_d;
  logic                   wr_en_d;
  logic [15:0]            wr_data_d;
  logic [DEPTH-1:0][15:0] words;
  logic [3:0]             op;
  logic                   xfer;

  assign op   = in_word[15:12];
  assign xfer = in_valid & in_ready_q;

  // Next-state, counter, error flags and store write request
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;
    clear_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = HALT_WORD;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d   = S_LOAD;
          count_d   = '0;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
          clear_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          state_d   = S_LOAD;
          count_d   = '0;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
          clear_d   = 1'b1;
        end else begin
          if (xfer) begin
            if (op == OP_HALT) begin
              wr_en_d   = 1'b1;
              wr_data_d = in_word;
              count_d   = count_q + CW'(1);
              state_d   = S_DONE;
            end else if (op == OP_ADD || op == OP_SUB) begin
              // The last slot is held back so a halt always fits
              if (count_q < CW'(DEPTH - 1)) begin
                wr_en_d   = 1'b1;
                wr_data_d = in_word;
                count_d   = count_q + CW'(1);
              end else begin
                err_ovf_d = 1'b1;
                state_d   = S_SEAL;
              end
            end else begin
              err_ill_d = 1'b1;
            end
          end
          if (load_end && state_d == S_LOAD) begin
            state_d = S_SEAL;
          end
        end
      end
      S_SEAL: begin
        wr_en_d   = 1'b1;
        wr_data_d = HALT_WORD;
        count_d   = count_q + CW'(1);
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      err_ill_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_ill_q   <= err_ill_d;
      err_ovf_q   <= err_ovf_d;
      in_ready_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_SEAL);
      done_q      <= (state_d == S_DONE);
      cpu_start_q <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  // Program store; word 0 sits at the MSB end of prog_image
  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    logic [15:0] word_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= HALT_WORD;
      end else if (clear_d) begin
        word_q <= HALT_WORD;
      end else if (wr_en_d && count_q == CW'(k)) begin
        word_q <= wr_data_d;
      end
    end
    assign words[k] = word_q;
    assign prog_image[(DEPTH-1-k)*16 +: 16] = word_q;
  end

  assign in_ready     = in_ready_q;
  assign word_count   = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_start    = cpu_start_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;

`ifdef PROG_LOADER_READBACK_EN
  logic [15:0] rd_data_q;

  // Registered readback; addresses past the store read as halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (CW'(rd_addr) < CW'(DEPTH)) begin
      rd_data_q <= words[rd_addr];
    end else begin
      rd_data_q <= HALT_WORD;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_words;
  assign unused_words = ^words;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: DEPTH=2 and DEPTH=4 instances share one directed stimulus
// stream and are checked every cycle against a word-list model plus literal expectations.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0, load_end = 1'b0, in_valid = 1'b0;
  logic [15:0] in_word = '0;

  logic        rdy2, busy2, done2, cs2, ei2, eo2;
  logic [31:0] img2;
  logic [1:0]  wc2;
  logic        rdy4, busy4, done4, cs4, ei4, eo4;
  logic [63:0] img4;
  logic [2:0]  wc4;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(rdy2), .in_word(in_word), .prog_image(img2),
    .word_count(wc2), .busy(busy2), .done(done2), .cpu_start(cs2),
    .err_illegal(ei2), .err_overflow(eo2)
  );

  prog_loader #(.DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(rdy4), .in_word(in_word), .prog_image(img4),
    .word_count(wc4), .busy(busy4), .done(done4), .cpu_start(cs4),
    .err_illegal(ei4), .err_overflow(eo4)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int p2 = 0, p4 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: stored words as a list; everything past the count reads as halt
  logic [15:0] mw [2][4];
  int          mcnt [2];
  int          mph [2];   // 0 idle, 1 load, 2 seal, 3 done
  bit          meill [2], meovf [2], mstart [2];

  function automatic int dep(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic mrestart(input int d);
    mph[d] = 1; mcnt[d] = 0; meill[d] = 1'b0; meovf[d] = 1'b0;
  endtask

  task automatic mstep(input int d);
    logic [3:0] op;
    op = in_word[15:12];
    mstart[d] = 1'b0;
    if (reset) begin
      mph[d] = 0; mcnt[d] = 0; meill[d] = 1'b0; meovf[d] = 1'b0;
      return;
    end
    case (mph[d])
      0, 3: if (load_start) mrestart(d);
      1: begin
        if (load_start) mrestart(d);
        else begin
          if (in_valid) begin
            if (op == 4'hF) begin
              mw[d][mcnt[d]] = in_word; mcnt[d]++; mph[d] = 3; mstart[d] = 1'b1;
            end else if (op == 4'h0 || op == 4'h1) begin
              if (mcnt[d] < dep(d) - 1) begin
                mw[d][mcnt[d]] = in_word; mcnt[d]++;
              end else begin
                meovf[d] = 1'b1; mph[d] = 2;
              end
            end else begin
              meill[d] = 1'b1;
            end
          end
          if (mph[d] == 1 && load_end) mph[d] = 2;
        end
      end
      default: begin
        mw[d][mcnt[d]] = 16'hF000; mcnt[d]++; mph[d] = 3; mstart[d] = 1'b1;
      end
    endcase
  endtask

  function automatic logic [63:0] mimg(input int d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < dep(d); k++)
      r[(dep(d)-1-k)*16 +: 16] = (k < mcnt[d]) ? mw[d][k] : 16'hF000;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) mstep(d);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("d2.prog_image",   64'(img2),  mimg(0));
      check("d2.word_count",   64'(wc2),   64'(mcnt[0]));
      check("d2.in_ready",     64'(rdy2),  64'(mph[0] == 1));
      check("d2.busy",         64'(busy2), 64'(mph[0] == 1 || mph[0] == 2));
      check("d2.done",         64'(done2), 64'(mph[0] == 3));
      check("d2.cpu_start",    64'(cs2),   64'(mstart[0]));
      check("d2.err_illegal",  64'(ei2),   64'(meill[0]));
      check("d2.err_overflow", 64'(eo2),   64'(meovf[0]));
      check("d4.prog_image",   img4,       mimg(1));
      check("d4.word_count",   64'(wc4),   64'(mcnt[1]));
      check("d4.in_ready",     64'(rdy4),  64'(mph[1] == 1));
      check("d4.busy",         64'(busy4), 64'(mph[1] == 1 || mph[1] == 2));
      check("d4.done",         64'(done4), 64'(mph[1] == 3));
      check("d4.cpu_start",    64'(cs4),   64'(mstart[1]));
      check("d4.err_illegal",  64'(ei4),   64'(meill[1]));
      check("d4.err_overflow", 64'(eo4),   64'(meovf[1]));
    end
  end

  always @(negedge clk) begin
    if (cs2) p2++;
    if (cs4) p4++;
  end

  task automatic cyc(input logic ls, input logic le, input logic iv, input logic [15:0] w);
    load_start = ls; load_end = le; in_valid = iv; in_word = w;
    @(posedge clk); #1;
    load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst d4 image", img4, 64'hF000F000F000F000);
    check("rst d4 count", 64'(wc4), 64'd0);
    check("rst d4 ready", 64'(rdy4), 64'd0);
    check("rst d2 image", 64'(img2), 64'hF000F000);
    reset = 1'b0;

    // DEPTH=2 program with explicit halt
    p2 = 0; p4 = 0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0123);
    cyc(1'b0, 1'b0, 1'b1, 16'hF000);
    check("s1 d2 image", 64'(img2), 64'h0123F000);
    check("s1 d2 count", 64'(wc2), 64'd2);
    check("s1 d2 done", 64'(done2), 64'd1);
    check("s1 d2 cpu_start", 64'(cs2), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("s1 d2 pulses", 64'(p2), 64'd1);
    check("s1 d4 image", img4, 64'h0123F000F000F000);

    // load_end seals through SEAL
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h1456);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    check("s2 d4 done@1", 64'(done4), 64'd0);
    check("s2 d4 busy@1", 64'(busy4), 64'd1);
    check("s2 d4 ready@1", 64'(rdy4), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("s2 d4 done@2", 64'(done4), 64'd1);
    check("s2 d4 count", 64'(wc4), 64'd2);
    check("s2 d4 image", img4, 64'h1456F000F000F000);

    // DEPTH=2 overflow
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0111);
    cyc(1'b0, 1'b0, 1'b1, 16'h0222);
    check("s3 d2 ovf", 64'(eo2), 64'd1);
    check("s3 d2 done early", 64'(done2), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("s3 d2 done", 64'(done2), 64'd1);
    check("s3 d2 image", 64'(img2), 64'h0111F000);
    check("s3 d2 count", 64'(wc2), 64'd2);

    // Illegal opcode dropped
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    check("s4 d2 ovf cleared", 64'(eo2), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h7AAA);
    check("s4 d4 ill", 64'(ei4), 64'd1);
    check("s4 d4 count", 64'(wc4), 64'd0);
    check("s4 d4 ready", 64'(rdy4), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'hF000);
    check("s4 d4 done", 64'(done4), 64'd1);
    check("s4 d4 count2", 64'(wc4), 64'd1);
    check("s4 d4 image", img4, 64'hF000F000F000F000);

    // Reset mid-load
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0ABC);
    check("s5 d4 pre image", img4, 64'h0ABCF000F000F000);
    reset = 1'b1;
    #1;
    check("s5 d4 rst image", img4, 64'hF000F000F000F000);
    check("s5 d4 rst count", 64'(wc4), 64'd0);
    check("s5 d4 rst busy", 64'(busy4), 64'd0);
    check("s5 d2 rst image", 64'(img2), 64'hF000F000);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h1222);
    cyc(1'b0, 1'b0, 1'b1, 16'hF000);
    check("s5 d4 image", img4, 64'h1222F000F000F000);
    check("s5 d4 count", 64'(wc4), 64'd2);

    // Restart beats a simultaneous transfer
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h7000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0444);
    check("s6 d4 ill", 64'(ei4), 64'd1);
    check("s6 d4 count", 64'(wc4), 64'd1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0333);
    check("s6 d4 restart count", 64'(wc4), 64'd0);
    check("s6 d4 restart ill", 64'(ei4), 64'd0);
    check("s6 d4 restart image", img4, 64'hF000F000F000F000);
    cyc(1'b0, 1'b1, 1'b1, 16'h0555);
    check("s6 d4 seal count", 64'(wc4), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("s6 d4 image", img4, 64'h0555F000F000F000);
    check("s6 d2 image", 64'(img2), 64'h0555F000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0999);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    check("s6 d4 held count", 64'(wc4), 64'd2);
    check("s6 d4 held done", 64'(done4), 64'd1);

    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
